ghost_mover: RTL and testbench
==============================

Name: ghost_mover

Overview:
- Ghost motion executor; the consumer end of the ghost direction-decision interface.
- Owns the ghost tile position and scans the maze wall ROM for the four neighbours of the current tile.
- Publishes canMoveU/R/D/L to the direction-decision logic and applies the returned dirToMove on each movement tick.
- Sits between the maze ROM and the decision logic; ghostPosX/Y feed the renderer and collision logic.

Parameters:
- MAP_W, 28, maze width in tiles.
- MAP_H, 31, maze height in tiles.
- X_BITS, 5, width of the X coordinate.
- Y_BITS, 5, width of the Y coordinate.
- START_X, 13, X tile loaded on reset.
- START_Y, 11, Y tile loaded on reset.
- TUNNEL_Y, 14, row on which X wraps horizontally.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- moveTick  in  1  single-cycle pulse; request one tile step.
- dirToMove  in  2  chosen direction: 00 Up, 01 Right, 10 Down, 11 Left.
- mapRdEn  out  1  wall ROM read strobe.
- mapAddrX  out  X_BITS  ROM tile X.
- mapAddrY  out  Y_BITS  ROM tile Y.
- mapWall  in  1  ROM data; 1 = wall; valid exactly 1 cycle after mapRdEn.
- canMoveU, canMoveR, canMoveD, canMoveL  out  1 each  legal-move flags.
- flagsValid  out  1  flags describe the current position.
- ghostPosX  out  X_BITS  current tile X.
- ghostPosY  out  Y_BITS  current tile Y.
- lastDir  out  2  direction of the last executed step.

Behaviour:
- Reset (reset=0, asynchronous):
  - ghostPosX=START_X, ghostPosY=START_Y.
  - canMove*=0, flagsValid=0, lastDir=00.
  - revValid=0, mapRdEn=0, pending=0.
  - State=SCAN_U. A scan therefore starts on the first clk after reset releases.
- FSM states: SCAN_U, SCAN_R, SCAN_D, SCAN_L, SCAN_END, READY.
- SCAN_x (one cycle each):
  - Drive the neighbour address for direction x. Up is y-1, Down is y+1, Left is x-1, Right is x+1.
  - Assert mapRdEn only when the neighbour is in bounds.
  - Capture mapWall for the previous direction into a raw flag register.
  - An out-of-bounds neighbour gives raw flag=0 with mapRdEn=0. The cycle is still spent.
- Tunnel wrap applies only when ghostPosY==TUNNEL_Y:
  - Left at x=0 addresses x=MAP_W-1.
  - Right at x=MAP_W-1 addresses x=0.
  - Both neighbours are in bounds in these cases.
- SCAN_END:
  - Capture the Left raw flag.
  - Apply the no-reverse mask: if revValid=1, clear the flag opposite lastDir, unless that leaves all four flags 0.
  - Load canMove* atomically, set flagsValid=1, go to READY.
- Scan latency: 5 cycles from scan entry to flagsValid=1.
- READY with moveTick=1 (or pending=1):
  - If canMove[dirToMove]=1: update the position with wrap, set lastDir=dirToMove, set revValid=1.
  - If canMove[dirToMove]=0: hold the position and lastDir.
  - In both cases clear pending, drop flagsValid to 0, and enter SCAN_U in the next cycle.
  - The position update is visible the cycle after the tick.
- Position arithmetic: X wraps modulo MAP_W only on TUNNEL_Y. Y never wraps. A flagged move never leaves the map.
- moveTick while not READY: set pending=1. Further ticks before service are dropped, so at most one tick is buffered. Pending is serviced on the first READY cycle.
- During a scan, canMove* hold their previous values and flagsValid=0.
- Reset asserted mid-scan aborts the scan. Everything returns to the reset values and no stale ROM data is captured.

Decomposition:
- Package pacman_pkg holds:
  - dir_t enum: UP=0, RIGHT=1, DOWN=2, LEFT=3.
  - opposite-direction function.
  - MAP_W, MAP_H, TUNNEL_Y constants.
- Sub-module ghost_neighbor_addr (combinational) takes the position and a direction. It outputs the neighbour X/Y, an inBounds flag, and the wrapped stepped position. It is reused for scan addressing and for the move update.

Test Plan:
- Reset released, ROM all zeros at (13,11):
  - mapRdEn pulses exactly 4 times.
  - flagsValid=1 five cycles after the scan starts.
  - All canMove*=1, since revValid=0 gives no mask.
- From (13,11) with all-open ROM, moveTick with dirToMove=01:
  - Position becomes (14,11) and lastDir=01.
  - After the rescan, canMoveL=0 and U/R/D=1.
- Ghost at (0,14), dirToMove=11, tick:
  - Scan addresses (27,14) for Left.
  - Position becomes (27,14).
  - Same case at (0,13): canMoveL=0 with no ROM read issued for Left.
- Dead end (walls U/R/D) with lastDir=01 (Right):
  - canMoveL=1 despite the reverse mask, because it is the only option.
- Two moveTick pulses during a scan:
  - Exactly one step is executed at READY.
  - Position advances by 1 tile only.
- reset=0 in SCAN_D:
  - Outputs immediately return to (13,11), flags 0.
  - A fresh 5-cycle scan follows release.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared maze constants, direction encoding and mover FSM states for the ghost logic.
package pacman_pkg;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      RIGHT = 2'd1,
      DOWN  = 2'd2,
      LEFT  = 2'd3
   } dir_t;

   typedef enum logic [2:0] {
      SCAN_U,
      SCAN_R,
      SCAN_D,
      SCAN_L,
      SCAN_END,
      READY
   } mover_state_t;

   localparam int MAP_W    = 28;
   localparam int MAP_H    = 31;
   localparam int TUNNEL_Y = 14;

   // Up<->Down and Right<->Left differ only in the upper encoding bit.
   function automatic dir_t oppositeDir(input dir_t d);
      return dir_t'(d ^ 2'b10);
   endfunction

endpackage

// File: rtl/ghost_neighbor_addr.sv
// Neighbour tile of a position in one direction, with tunnel wrap and a map-bounds flag.
module ghost_neighbor_addr
   import pacman_pkg::*;
#(
   parameter int X_BITS   = 5,
   parameter int Y_BITS   = 5,
   parameter int MAP_W    = 28,
   parameter int MAP_H    = 31,
   parameter int TUNNEL_Y = 14
) (
   input  logic [X_BITS-1:0] posX_i,
   input  logic [Y_BITS-1:0] posY_i,
   input  dir_t              dir_i,
   output logic [X_BITS-1:0] nbrX_o,
   output logic [Y_BITS-1:0] nbrY_o,
   output logic              inBounds_o,
   output logic [X_BITS-1:0] stepX_o,
   output logic [Y_BITS-1:0] stepY_o
);

   localparam logic [X_BITS-1:0] X_ONE  = X_BITS'(1);
   localparam logic [Y_BITS-1:0] Y_ONE  = Y_BITS'(1);
   localparam logic [X_BITS-1:0] X_LAST = X_BITS'(MAP_W - 1);
   localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(MAP_H - 1);
   localparam logic [Y_BITS-1:0] Y_TUN  = Y_BITS'(TUNNEL_Y);

   logic onTunnel;

   assign onTunnel = (posY_i == Y_TUN);

   always_comb begin
      nbrX_o     = posX_i;
      nbrY_o     = posY_i;
      inBounds_o = 1'b1;
      case (dir_i)
         UP: begin
            nbrY_o     = posY_i - Y_ONE;
            inBounds_o = (posY_i != '0);
         end
         RIGHT: begin
            if (posX_i != X_LAST) nbrX_o = posX_i + X_ONE;
            else if (onTunnel)    nbrX_o = '0;
            else                  inBounds_o = 1'b0;
         end
         DOWN: begin
            nbrY_o     = posY_i + Y_ONE;
            inBounds_o = (posY_i != Y_LAST);
         end
         LEFT: begin
            if (posX_i != '0)  nbrX_o = posX_i - X_ONE;
            else if (onTunnel) nbrX_o = X_LAST;
            else               inBounds_o = 1'b0;
         end
         default: ;
      endcase
   end

   // Off-map steps hold the current tile so a stray move can never leave the maze.
   assign stepX_o = inBounds_o ? nbrX_o : posX_i;
   assign stepY_o = inBounds_o ? nbrY_o : posY_i;

endmodule

// File: rtl/ghost_mover.sv
// Ghost motion executor: scans the wall ROM around the ghost, publishes legal-move
// flags to the decision logic and applies the chosen direction on each movement tick.
module ghost_mover
   import pacman_pkg::*;
#(
   parameter int MAP_W    = pacman_pkg::MAP_W,
   parameter int MAP_H    = pacman_pkg::MAP_H,
   parameter int X_BITS   = 5,
   parameter int Y_BITS   = 5,
   parameter int START_X  = 13,
   parameter int START_Y  = 11,
   parameter int TUNNEL_Y = pacman_pkg::TUNNEL_Y
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              moveTick,
   input  logic [1:0]        dirToMove,
   output logic              mapRdEn,
   output logic [X_BITS-1:0] mapAddrX,
   output logic [Y_BITS-1:0] mapAddrY,
   input  logic              mapWall,
   output logic              canMoveU,
   output logic              canMoveR,
   output logic              canMoveD,
   output logic              canMoveL,
   output logic              flagsValid,
   output logic [X_BITS-1:0] ghostPosX,
   output logic [Y_BITS-1:0] ghostPosY,
   output logic [1:0]        lastDir
);

   mover_state_t      state_q, state_d;
   logic [X_BITS-1:0] posX_q, posX_d;
   logic [Y_BITS-1:0] posY_q, posY_d;
   dir_t              lastDir_q, lastDir_d;
   logic              revValid_q, revValid_d;
   logic              pending_q, pending_d;
   logic              flagsValid_q, flagsValid_d;
   logic [3:0]        canMove_q, canMove_d;
   logic [3:0]        raw_q, raw_d;
   logic              rdEnPrev_q;

   logic [3:0]        rawAll, masked;
   logic              scanning, nbrInBounds, openBit;
   dir_t              nbrDir, moveDir;
   logic [X_BITS-1:0] nbrX, stepX;
   logic [Y_BITS-1:0] nbrY, stepY;

   assign moveDir = dir_t'(dirToMove);

   ghost_neighbor_addr #(
      .X_BITS   (X_BITS),
      .Y_BITS   (Y_BITS),
      .MAP_W    (MAP_W),
      .MAP_H    (MAP_H),
      .TUNNEL_Y (TUNNEL_Y)
   ) uNbr (
      .posX_i     (posX_q),
      .posY_i     (posY_q),
      .dir_i      (nbrDir),
      .nbrX_o     (nbrX),
      .nbrY_o     (nbrY),
      .inBounds_o (nbrInBounds),
      .stepX_o    (stepX),
      .stepY_o    (stepY)
   );

   // One neighbour calculator serves both the scan address and the move target.
   always_comb begin
      scanning = 1'b1;
      nbrDir   = moveDir;
      case (state_q)
         SCAN_U:  nbrDir = UP;
         SCAN_R:  nbrDir = RIGHT;
         SCAN_D:  nbrDir = DOWN;
         SCAN_L:  nbrDir = LEFT;
         default: scanning = 1'b0;
      endcase
   end

   // The reset state is SCAN_U, so the strobe is also qualified by reset being released.
   assign mapRdEn  = scanning & nbrInBounds & reset;
   assign mapAddrX = nbrX;
   assign mapAddrY = nbrY;
   assign openBit  = rdEnPrev_q & ~mapWall;

   always_comb begin
      state_d      = state_q;
      posX_d       = posX_q;
      posY_d       = posY_q;
      lastDir_d    = lastDir_q;
      revValid_d   = revValid_q;
      pending_d    = pending_q;
      flagsValid_d = flagsValid_q;
      canMove_d    = canMove_q;
      raw_d        = raw_q;
      rawAll       = {openBit, raw_q[2:0]};
      masked       = rawAll & ~(4'b0001 << oppositeDir(lastDir_q));

      case (state_q)
         SCAN_U: state_d = SCAN_R;
         SCAN_R: begin
            raw_d[UP] = openBit;
            state_d   = SCAN_D;
         end
         SCAN_D: begin
            raw_d[RIGHT] = openBit;
            state_d      = SCAN_L;
         end
         SCAN_L: begin
            raw_d[DOWN] = openBit;
            state_d     = SCAN_END;
         end
         SCAN_END: begin
            // Reversing is only forbidden while some other exit exists.
            canMove_d    = (revValid_q && (masked != 4'b0000)) ? masked : rawAll;
            flagsValid_d = 1'b1;
            state_d      = READY;
         end
         READY: begin
            if (moveTick || pending_q) begin
               if (canMove_q[moveDir]) begin
                  posX_d     = stepX;
                  posY_d     = stepY;
                  lastDir_d  = moveDir;
                  revValid_d = 1'b1;
               end
               pending_d    = 1'b0;
               flagsValid_d = 1'b0;
               state_d      = SCAN_U;
            end
         end
         default: state_d = SCAN_U;
      endcase

      if (moveTick && (state_q != READY)) pending_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= SCAN_U;
         posX_q       <= X_BITS'(START_X);
         posY_q       <= Y_BITS'(START_Y);
         lastDir_q    <= UP;
         revValid_q   <= 1'b0;
         pending_q    <= 1'b0;
         flagsValid_q <= 1'b0;
         canMove_q    <= 4'b0000;
         raw_q        <= 4'b0000;
         rdEnPrev_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         posX_q       <= posX_d;
         posY_q       <= posY_d;
         lastDir_q    <= lastDir_d;
         revValid_q   <= revValid_d;
         pending_q    <= pending_d;
         flagsValid_q <= flagsValid_d;
         canMove_q    <= canMove_d;
         raw_q        <= raw_d;
         rdEnPrev_q   <= mapRdEn;
      end
   end

   assign canMoveU   = canMove_q[UP];
   assign canMoveR   = canMove_q[RIGHT];
   assign canMoveD   = canMove_q[DOWN];
   assign canMoveL   = canMove_q[LEFT];
   assign flagsValid = flagsValid_q;
   assign ghostPosX  = posX_q;
   assign ghostPosY  = posY_q;
   assign lastDir    = lastDir_q;

endmodule

// File: tb/tb_ghost_mover.sv
// Scoreboard bench for ghost_mover: a tile-level maze model predicts every scan result,
// and a monitor checks each published flag set together with the ROM reads behind it.
module tb_ghost_mover;

   localparam int MAP_W    = 28;
   localparam int MAP_H    = 31;
   localparam int TUNNEL_Y = 14;

   typedef struct {
      int x;
      int y;
      int flags;
      int dir;
      int reads;
      int addr[4];
   } expect_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       moveTick;
   logic [1:0] dirToMove;
   logic       mapRdEn;
   logic [4:0] mapAddrX, mapAddrY;
   logic       mapWall = 1'b0;
   logic       canMoveU, canMoveR, canMoveD, canMoveL, flagsValid;
   logic [4:0] ghostPosX, ghostPosY;
   logic [1:0] lastDir;

   bit      wall [MAP_W][MAP_H];
   expect_t sb[$];
   expect_t monItem;
   int      numChecks = 0;
   int      numErrors = 0;
   int      mX, mY, mLast, mFlags;
   bit      mRev;
   int      rdCount = 0;
   int      rdAddr[4];
   bit      fvPrev = 1'b0;

   always #5 clk = ~clk;

   ghost_mover dut (
      .clk        (clk),
      .reset      (reset),
      .moveTick   (moveTick),
      .dirToMove  (dirToMove),
      .mapRdEn    (mapRdEn),
      .mapAddrX   (mapAddrX),
      .mapAddrY   (mapAddrY),
      .mapWall    (mapWall),
      .canMoveU   (canMoveU),
      .canMoveR   (canMoveR),
      .canMoveD   (canMoveD),
      .canMoveL   (canMoveL),
      .flagsValid (flagsValid),
      .ghostPosX  (ghostPosX),
      .ghostPosY  (ghostPosY),
      .lastDir    (lastDir)
   );

   // Wall ROM: data one cycle after a strobe, open (0) whenever nothing was read.
   always @(posedge clk) begin
      if (mapRdEn && mapAddrX < MAP_W && mapAddrY < MAP_H) mapWall <= wall[mapAddrX][mapAddrY];
      else mapWall <= 1'b0;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      numChecks++;
      if (act !== exp) begin
         numErrors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic bit neighbour(input int d, input int x, input int y, output int nx, output int ny);
      int dx[4] = '{0, 1, 0, -1};
      int dy[4] = '{-1, 0, 1, 0};
      nx = x + dx[d];
      ny = y + dy[d];
      if (y == TUNNEL_Y) nx = (nx + MAP_W) % MAP_W;
      return (nx >= 0 && nx < MAP_W && ny >= 0 && ny < MAP_H);
   endfunction

   task automatic modelReset();
      mX = 13; mY = 11; mLast = 0; mRev = 1'b0; mFlags = 0;
      sb.delete();
   endtask

   task automatic modelScan();
      expect_t e;
      int nx, ny, m;
      int raw = 0;
      e.reads = 0;
      for (int d = 0; d < 4; d++) begin
         e.addr[d] = 0;
         if (neighbour(d, mX, mY, nx, ny)) begin
            e.addr[e.reads] = nx * 32 + ny;
            e.reads++;
            if (!wall[nx][ny]) raw |= (1 << d);
         end
      end
      mFlags = raw;
      if (mRev) begin
         m = raw & ~(1 << ((mLast + 2) % 4));
         if (m != 0) mFlags = m;
      end
      e.x = mX; e.y = mY; e.flags = mFlags; e.dir = mLast;
      sb.push_back(e);
   endtask

   task automatic modelMove(input int d);
      int nx, ny;
      if (((mFlags >> d) & 1) == 1) begin
         void'(neighbour(d, mX, mY, nx, ny));
         mX = nx; mY = ny; mLast = d; mRev = 1'b1;
      end
   endtask

   // Monitor: every rising flagsValid is one scan result to be matched against the scoreboard.
   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         rdCount = 0;
         fvPrev  = 1'b0;
      end else begin
         if (mapRdEn === 1'b1) begin
            if (rdCount < 4) rdAddr[rdCount] = int'(mapAddrX) * 32 + int'(mapAddrY);
            rdCount++;
         end
         if (flagsValid === 1'b1 && !fvPrev) begin
            if (sb.size() == 0) begin
               numChecks++;
               numErrors++;
               $display("[TB] FAIL unexpectedScan: got flagsValid=1 at (%0d,%0d), expected no scan result", ghostPosX, ghostPosY);
            end else begin
               monItem = sb.pop_front();
               checkOutput("posX", 32'(ghostPosX), monItem.x);
               checkOutput("posY", 32'(ghostPosY), monItem.y);
               checkOutput("canMoveLDRU", 32'({canMoveL, canMoveD, canMoveR, canMoveU}), monItem.flags);
               checkOutput("lastDir", 32'(lastDir), monItem.dir);
               checkOutput("romReads", rdCount, monItem.reads);
               for (int k = 0; k < monItem.reads && k < rdCount && k < 4; k++)
                  checkOutput("romAddr", rdAddr[k], monItem.addr[k]);
            end
            rdCount = 0;
         end
         fvPrev = (flagsValid === 1'b1);
      end
   end

   task automatic waitIdle();
      int n = 0;
      while ((sb.size() != 0 || flagsValid !== 1'b1) && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) begin
         numChecks++;
         numErrors++;
         $display("[TB] FAIL idleTimeout: got %0d queued results after %0d cycles, expected 0", sb.size(), n);
         sb.delete();
      end
   endtask

   task automatic releaseAndScan();
      int cnt = 0;
      @(posedge clk);
      #2 reset = 1'b1;
      modelScan();
      while (flagsValid !== 1'b1 && cnt < 20) begin
         @(posedge clk);
         #1 cnt++;
      end
      checkOutput("scanLatency", cnt, 5);
      waitIdle();
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "PosX"}, 32'(ghostPosX), 13);
      checkOutput({tag, "PosY"}, 32'(ghostPosY), 11);
      checkOutput({tag, "FlagsValid"}, 32'(flagsValid), 0);
      checkOutput({tag, "CanMove"}, 32'({canMoveL, canMoveD, canMoveR, canMoveU}), 0);
      checkOutput({tag, "LastDir"}, 32'(lastDir), 0);
      checkOutput({tag, "MapRdEn"}, 32'(mapRdEn), 0);
   endtask

   // One tick in READY; optionally two more ticks mid-scan, of which only one may be kept.
   task automatic applyStimulus(input int d, input bit extra, input int d2);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      dirToMove = 2'(d);
      moveTick  = 1'b1;
      modelMove(d);
      modelScan();
      @(negedge clk);
      moveTick = 1'b0;
      if (extra) begin
         @(negedge clk);
         dirToMove = 2'(d2);
         moveTick  = 1'b1;
         @(negedge clk);
         moveTick = 1'b0;
         @(negedge clk);
         moveTick = 1'b1;
         @(negedge clk);
         moveTick = 1'b0;
         modelMove(d2);
         modelScan();
      end
      waitIdle();
   endtask

   task automatic resetDuringScan();
      int d = 0;
      for (int k = 3; k >= 0; k--) if (((mFlags >> k) & 1) == 1) d = k;
      @(negedge clk);
      dirToMove = 2'(d);
      moveTick  = 1'b1;
      @(negedge clk);
      moveTick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1 checkResetState("midReset");
      modelReset();
      repeat (2) @(negedge clk);
      releaseAndScan();
   endtask

   initial begin
      reset     = 1'b1;
      moveTick  = 1'b0;
      dirToMove = 2'd0;
      foreach (wall[x, y]) wall[x][y] = 1'b0;
      modelReset();
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      #1 checkResetState("reset");
      releaseAndScan();

      applyStimulus(1, 1'b0, 0);
      wall[15][10] = 1'b1;
      wall[16][11] = 1'b1;
      wall[15][12] = 1'b1;
      applyStimulus(1, 1'b0, 0);
      wall[15][10] = 1'b0;
      wall[16][11] = 1'b0;
      wall[15][12] = 1'b0;
      applyStimulus(3, 1'b0, 0);
      repeat (2) applyStimulus(2, 1'b0, 0);
      repeat (14) applyStimulus(3, 1'b0, 0);
      applyStimulus(2, 1'b0, 0);
      applyStimulus(3, 1'b0, 0);
      applyStimulus(3, 1'b1, 3);

      resetDuringScan();

      for (int i = 0; i < 40; i++) begin
         if (i % 8 == 0) foreach (wall[x, y]) wall[x][y] = ($urandom_range(0, 3) == 0);
         applyStimulus($urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
      $finish;
   end

endmodule
